// File: rtl/avalon_rr_burst_arbiter_if.sv
// rtl/avalon_rr_burst_arbiter_if.sv - handshake bundle between Avalon masters, arbiter and mux
//
// Purpose: groups the per-master request/burst signals, the slave waitrequest
//          returned through the mux, and the arbiter's select/waitrequest/busy outputs.
// Signals:
//   i_AVIn_Read          [NUM_INPUTS]    per-master read request
//   i_AVIn_Write         [NUM_INPUTS]    per-master write request
//   i_AVIn_BurstCount    [8*NUM_INPUTS]  per-master burst length, master k at [8k+:8]
//   i_AVOut_WaitRequest  [1]             slave waitrequest seen through the mux
//   o_MuxSel             [SW]            mux select, 0 = terminated, k+1 = master k
//   o_AVIn_WaitRequest   [NUM_INPUTS]    per-master waitrequest
//   o_Busy               [1]             high while a grant is held
// Modports: slave = arbiter side, master = stimulus/master side.
interface avalon_rr_burst_arbiter_if #(
   parameter int NUM_INPUTS = 2
);
   localparam int SW = $clog2(NUM_INPUTS + 1);

   logic [NUM_INPUTS-1:0]   i_AVIn_Read;
   logic [NUM_INPUTS-1:0]   i_AVIn_Write;
   logic [8*NUM_INPUTS-1:0] i_AVIn_BurstCount;
   logic                    i_AVOut_WaitRequest;
   logic [SW-1:0]           o_MuxSel;
   logic [NUM_INPUTS-1:0]   o_AVIn_WaitRequest;
   logic                    o_Busy;

   modport slave (
      input  i_AVIn_Read, i_AVIn_Write, i_AVIn_BurstCount, i_AVOut_WaitRequest,
      output o_MuxSel, o_AVIn_WaitRequest, o_Busy
   );

   modport master (
      output i_AVIn_Read, i_AVIn_Write, i_AVIn_BurstCount, i_AVOut_WaitRequest,
      input  o_MuxSel, o_AVIn_WaitRequest, o_Busy
   );
endinterface

// File: rtl/avalon_rr_burst_arbiter.sv
// rtl/avalon_rr_burst_arbiter.sv - round-robin burst-holding arbiter driving an Avalon terminated mux
//
// Purpose: picks one requesting master in round-robin order, holds the mux on it
//          for its whole burst (counting accepted beats), then re-arbitrates in the
//          release cycle so back-to-back grants have no idle bubble.
// Ports:
//   i_Clk    in  system clock, rising edge
//   i_Rst_n  in  asynchronous active-low reset
//   bus      slave modport of avalon_rr_burst_arbiter_if (requests, burst counts,
//            slave waitrequest in; mux select, per-master waitrequest, busy out)
module avalon_rr_burst_arbiter #(
   parameter int NUM_INPUTS = 2
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst_n,
   avalon_rr_burst_arbiter_if.slave     bus
);
   localparam int SW = $clog2(NUM_INPUTS + 1);
   localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         sel_q, sel_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [PW-1:0]         ptr_q, ptr_d;    // first master searched on the next arbitration

   logic [NUM_INPUTS-1:0] req;
   logic [NUM_INPUTS-1:0] cur;             // one-hot of the granted master
   logic [NUM_INPUTS-1:0] cand;
   logic                  accept;
   logic [PW:0]           pick;            // {found, index}
   logic [PW-1:0]         win;
   logic [7:0]            win_bc;
   logic [NUM_INPUTS-1:0] wr;

   // Scans cand starting at start; the descending loop lets the lowest offset win.
   function automatic logic [PW:0] rr_pick(input logic [NUM_INPUTS-1:0] c,
                                           input logic [PW-1:0] start);
      logic [PW:0] r;
      int          idx;
      r = '0;
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % NUM_INPUTS;
         if (c[idx]) r = {1'b1, PW'(idx)};
      end
      return r;
   endfunction

   assign req = bus.i_AVIn_Read | bus.i_AVIn_Write;

   always_comb begin
      cur = '0;
      for (int k = 0; k < NUM_INPUTS; k++) cur[k] = (state_q == S_GRANT) && (sel_q == SW'(k + 1));
   end

   assign accept = (|(req & cur)) & ~bus.i_AVOut_WaitRequest;
   // In GRANT the current master is masked so a release always rotates away from it.
   assign cand   = (state_q == S_GRANT) ? (req & ~cur) : req;
   assign pick   = rr_pick(cand, ptr_q);
   assign win    = pick[PW-1:0];
   assign win_bc = bus.i_AVIn_BurstCount[8*int'(win) +: 8];

   // State register
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (pick[PW]) begin
               state_d = S_GRANT;
               sel_d   = SW'(int'(win) + 1);
               cnt_d   = (win_bc == 8'd0) ? 8'd1 : win_bc;
               ptr_d   = PW'((int'(win) + 1) % NUM_INPUTS);
            end
         end
         S_GRANT: begin
            if (accept && cnt_q != 8'd0) begin
               if (cnt_q == 8'd1) begin
                  if (pick[PW]) begin
                     sel_d = SW'(int'(win) + 1);
                     cnt_d = (win_bc == 8'd0) ? 8'd1 : win_bc;
                     ptr_d = PW'((int'(win) + 1) % NUM_INPUTS);
                  end else begin
                     state_d = S_IDLE;
                     sel_d   = '0;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            sel_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: waitrequest is combinational so the slave's wait reaches the master in-cycle.
   always_comb begin
      wr = '1;
      for (int k = 0; k < NUM_INPUTS; k++) wr[k] = ~cur[k] | bus.i_AVOut_WaitRequest;
   end

   assign bus.o_AVIn_WaitRequest = wr;
   assign bus.o_MuxSel           = sel_q;
   assign bus.o_Busy             = (state_q == S_GRANT);
endmodule

// File: tb/tb_avalon_rr_burst_arbiter.sv
// tb/tb_avalon_rr_burst_arbiter.sv - directed self-checking bench for avalon_rr_burst_arbiter
module tb_avalon_rr_burst_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   avalon_rr_burst_arbiter_if #(.NUM_INPUTS(2)) bus ();

   avalon_rr_burst_arbiter #(.NUM_INPUTS(2)) dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_AVIn_Read         = 2'b00;
      bus.i_AVIn_Write        = 2'b00;
      bus.i_AVIn_BurstCount   = 16'h0101;
      bus.i_AVOut_WaitRequest = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_AVIn_Read         = 2'b11;
      bus.i_AVIn_Write        = 2'b00;
      bus.i_AVIn_BurstCount   = 16'h0101;
      bus.i_AVOut_WaitRequest = 1'b0;
      cyc();
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", bus.o_MuxSel); end
      checks++; if (bus.o_AVIn_WaitRequest !== 2'b11) begin errors++; $display("FAIL reset_wr got %b want 11", bus.o_AVIn_WaitRequest); end
      checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_Busy); end
      rst_n = 1'b1;
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd1) begin errors++; $display("FAIL reset_first_grant got %0d want 1", bus.o_MuxSel); end
      checks++; if (bus.o_Busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got %b want 1", bus.o_Busy); end
      checks++; if (bus.o_AVIn_WaitRequest !== 2'b10) begin errors++; $display("FAIL reset_first_wr got %b want 10", bus.o_AVIn_WaitRequest); end
   endtask

   task automatic test_single_write();
      do_reset();
      bus.i_AVIn_Write      = 2'b10;
      bus.i_AVIn_BurstCount = 16'h0100;
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d want 2", bus.o_MuxSel); end
      checks++; if (bus.o_AVIn_WaitRequest !== 2'b01) begin errors++; $display("FAIL single_wr got %b want 01", bus.o_AVIn_WaitRequest); end
      cyc();
      bus.i_AVIn_Write = 2'b00;
      #1;
      checks++; if (bus.o_MuxSel !== 2'd0) begin errors++; $display("FAIL single_release_sel got %0d want 0", bus.o_MuxSel); end
      checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL single_release_busy got %b want 0", bus.o_Busy); end
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd0) begin errors++; $display("FAIL single_stay_idle got %0d want 0", bus.o_MuxSel); end
   endtask

   task automatic test_burst_hold();
      logic [5:0] wpat;
      int         held;
      wpat = 6'b000110;             // bit i = slave wait during held cycle i
      held = 0;
      do_reset();
      bus.i_AVIn_Read       = 2'b11;
      bus.i_AVIn_BurstCount = 16'h0104;
      cyc();
      for (int i = 0; i < 6; i++) begin
         bus.i_AVOut_WaitRequest = wpat[i];
         #1;
         if (bus.o_MuxSel == 2'd1) held++;
         checks++; if (bus.o_AVIn_WaitRequest[1] !== 1'b1) begin errors++; $display("FAIL burst_m1_wr cyc %0d got %b want 1", i, bus.o_AVIn_WaitRequest[1]); end
         checks++; if (bus.o_AVIn_WaitRequest[0] !== wpat[i]) begin errors++; $display("FAIL burst_m0_wr cyc %0d got %b want %b", i, bus.o_AVIn_WaitRequest[0], wpat[i]); end
         cyc();
      end
      bus.i_AVOut_WaitRequest = 1'b0;
      checks++; if (held !== 6) begin errors++; $display("FAIL burst_hold_cycles got %0d want 6", held); end
      checks++; if (bus.o_MuxSel !== 2'd2) begin errors++; $display("FAIL burst_handover got %0d want 2", bus.o_MuxSel); end
   endtask

   task automatic test_rr_fairness();
      logic [1:0] exp_sel [8];
      exp_sel = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};
      do_reset();
      bus.i_AVIn_Read       = 2'b11;
      bus.i_AVIn_BurstCount = 16'h0202;
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++; if (bus.o_MuxSel !== exp_sel[i]) begin errors++; $display("FAIL rr_sel cyc %0d got %0d want %0d", i, bus.o_MuxSel, exp_sel[i]); end
      end
   endtask

   task automatic test_zero_burst();
      do_reset();
      bus.i_AVIn_Read       = 2'b01;
      bus.i_AVIn_BurstCount = 16'h0000;
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd1) begin errors++; $display("FAIL zero_grant got %0d want 1", bus.o_MuxSel); end
      cyc();
      bus.i_AVIn_Read = 2'b00;
      #1;
      checks++; if (bus.o_MuxSel !== 2'd0) begin errors++; $display("FAIL zero_release got %0d want 0", bus.o_MuxSel); end
      checks++; if (bus.o_AVIn_WaitRequest !== 2'b11) begin errors++; $display("FAIL zero_idle_wr got %b want 11", bus.o_AVIn_WaitRequest); end
   endtask

   task automatic test_async_reset_mid_burst();
      do_reset();
      bus.i_AVIn_Read       = 2'b01;
      bus.i_AVIn_BurstCount = 16'h0003;
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd1) begin errors++; $display("FAIL async_pre_grant got %0d want 1", bus.o_MuxSel); end
      bus.i_AVOut_WaitRequest = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.o_MuxSel !== 2'd0) begin errors++; $display("FAIL async_sel got %0d want 0", bus.o_MuxSel); end
      checks++; if (bus.o_AVIn_WaitRequest !== 2'b11) begin errors++; $display("FAIL async_wr got %b want 11", bus.o_AVIn_WaitRequest); end
      checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", bus.o_Busy); end
      cyc();
      bus.i_AVIn_Read         = 2'b11;
      bus.i_AVOut_WaitRequest = 1'b0;
      rst_n = 1'b1;
      cyc();
      checks++; if (bus.o_MuxSel !== 2'd1) begin errors++; $display("FAIL async_fresh_grant got %0d want 1", bus.o_MuxSel); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_single_write();
      test_burst_hold();
      test_rr_fairness();
      test_zero_burst();
      test_async_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
